// File: rtl/adder_17.sv
// rtl/adder_17.sv - 17-bit registered adder built from 4-bit carry-lookahead groups plus a 1-bit top slice
// Optional overflow flag V is present when ADDER17_OVF_EN is defined.
module adder_17 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [16:0] A,
  input  logic [16:0] B,
  output logic [16:0] S,
  output logic        Cout
`ifdef ADDER17_OVF_EN
  ,
  output logic        V
`endif
);

  logic [16:0] p;
  logic [16:0] g;
  logic [16:0] sum_c;
  logic        cout_c;
  logic [4:0]  c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  ci;

  assign p = A ^ B;
  assign g = A & B;

  // c[k] is the carry into group k; each group resolves its carries from c[k] alone
  always_comb begin
    c      = '0;
    sum_c  = '0;
    cout_c = 1'b0;
    gp     = '0;
    gg     = '0;
    ci     = '0;
    for (int k = 0; k < 4; k++) begin
      gp    = p[4*k +: 4];
      gg    = g[4*k +: 4];
      ci[0] = c[k];
      ci[1] = gg[0] | (gp[0] & ci[0]);
      ci[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci[0]);
      ci[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & ci[0]);
      ci[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & ci[0]);
      sum_c[4*k +: 4] = gp ^ ci[3:0];
      c[k+1]          = ci[4];
    end
    sum_c[16] = p[16] ^ c[4];
    cout_c    = g[16] | (p[16] & c[4]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S    <= '0;
      Cout <= 1'b0;
    end else begin
      S    <= sum_c;
      Cout <= cout_c;
    end
  end

`ifdef ADDER17_OVF_EN
  // Signed overflow: like-signed operands producing a result of the other sign
  always_ff @(posedge clk) begin
    if (!rst_n) V <= 1'b0;
    else        V <= (A[16] == B[16]) && (sum_c[16] != A[16]);
  end
`endif

endmodule

// File: tb/tb_adder_17.sv
// tb/tb_adder_17.sv - directed and random self-checking bench for adder_17
// Overflow checks are included when ADDER17_OVF_EN is defined.
module tb_adder_17;

  logic        clk;
  logic        rst_n;
  logic [16:0] A;
  logic [16:0] B;
  logic [16:0] S;
  logic        Cout;
`ifdef ADDER17_OVF_EN
  logic        V;
`endif

  int n_tests;
  int n_fail;

  adder_17 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .S    (S),
    .Cout (Cout)
`ifdef ADDER17_OVF_EN
    ,
    .V    (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // apply operands, let one edge pass, then sample 1 time unit after it
  task automatic step(input logic r, input logic [16:0] a, input logic [16:0] b);
    rst_n = r;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [16:0] ra;
    logic [16:0] rb;
    logic [17:0] exp_sum;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    A       = '0;
    B       = '0;

    step(1'b0, 17'h1FFFF, 17'h1FFFF);
    check("rst0_sum", {14'd0, Cout, S}, 32'h0);
    step(1'b0, 17'h1FFFF, 17'h1FFFF);
    check("rst1_sum", {14'd0, Cout, S}, 32'h0);
`ifdef ADDER17_OVF_EN
    check("rst_v", {31'd0, V}, 32'h0);
`endif

    step(1'b1, 17'h00000, 17'h00000);
    check("zero", {14'd0, Cout, S}, 32'h0);
    step(1'b1, 17'h06667, 17'h18001);
    check("mixed", {14'd0, Cout, S}, 32'h0_1E668);
    step(1'b1, 17'h1FFFF, 17'h00001);
    check("ripple", {14'd0, Cout, S}, 32'h2_0000);
    step(1'b1, 17'h1FFFF, 17'h1FFFF);
    check("max_max", {14'd0, Cout, S}, 32'h3_FFFE);
    step(1'b1, 17'h0000F, 17'h00001);
    check("grp_bnd", {14'd0, Cout, S}, 32'h0_0010);
    step(1'b1, 17'h0FFFF, 17'h00001);
    check("to_bit16", {14'd0, Cout, S}, 32'h1_0000);
`ifdef ADDER17_OVF_EN
    check("ovf_set", {31'd0, V}, 32'h1);
`endif
    step(1'b0, 17'h0FFFF, 17'h00001);
    check("mid_rst", {14'd0, Cout, S}, 32'h0);
`ifdef ADDER17_OVF_EN
    check("mid_rst_v", {31'd0, V}, 32'h0);
`endif
    step(1'b1, 17'h12345, 17'h00001);
    check("post_rst", {14'd0, Cout, S}, 32'h1_2346);
    step(1'b1, 17'h10000, 17'h10000);
    check("top_carry", {14'd0, Cout, S}, 32'h2_0000);
`ifdef ADDER17_OVF_EN
    check("ovf_neg", {31'd0, V}, 32'h1);
`endif

    for (int i = 0; i < 10000; i++) begin
      ra      = 17'($urandom);
      rb      = 17'($urandom);
      exp_sum = {1'b0, ra} + {1'b0, rb};
      step(1'b1, ra, rb);
      check("random", {14'd0, Cout, S}, {14'd0, exp_sum});
`ifdef ADDER17_OVF_EN
      check("random_v", {31'd0, V},
            {31'd0, (ra[16] == rb[16]) && (exp_sum[16] != ra[16])});
`endif
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
